// File: rtl/run_controller.sv
// run_controller: sequences the pipelined Beta CPU between host-load and execution.
// Drives the CPU alive input; accepts RUN/STEP/STOP/CLEAR commands over valid/ready,
// detects halt, and counts alive cycles and retired instructions (saturating).
// Optional watchdog: define RUN_CTRL_WDT_EN to build the no-retire watchdog;
// without it wdt_err is tied low and WDT_CYC is unused.
module run_controller #(
  parameter int CNT_W   = 32,
  parameter int STEP_W  = 16,
  parameter int WDT_CYC = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] step_n,
  input  logic [4:0]        clk_sequence,
  input  logic              halt,
  output logic              alive,
  output logic [2:0]        state,
  output logic              done,
  output logic              cmd_err,
  output logic              wdt_err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STEP     = 3'd2,
    ST_STOPPING = 3'd3,
    ST_HALTED   = 3'd4
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_t              state_reg, state_next;
  logic                alive_reg;
  logic                done_reg;
  logic                cmd_err_reg, cmd_err_next;
  logic [STEP_W-1:0]   steps_reg, steps_next;
  logic [CNT_W-1:0]    cycle_reg, cycle_next;
  logic [CNT_W-1:0]    instr_reg, instr_next;
  logic                retire;
  logic                accept;
  logic                wdt_fire;

  // Only the final (RFW) stage enable marks a retire; earlier stage bits are not needed.
  logic unused_stage_bits;
  assign unused_stage_bits = ^clk_sequence[3:0];

  assign retire    = alive_reg & clk_sequence[4];
  // STOPPING is waiting for an instruction boundary and cannot take new work.
  assign cmd_ready = (state_reg != ST_STOPPING);
  assign accept    = cmd_valid & cmd_ready;

`ifdef RUN_CTRL_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);

  logic [WDT_W-1:0] idle_cnt_reg;
  logic             wdt_err_reg;

  // The cycle that would bring the idle count up to WDT_CYC fires the watchdog.
  assign wdt_fire = alive_reg & ~retire & (idle_cnt_reg == WDT_W'(WDT_CYC - 1));

  // Idle counter: alive cycles since the last retire; held at zero while not alive,
  // which also gives a fresh count on entry to RUN/STEP.
  always_ff @(posedge clk) begin
    if (!rst_n || !alive_reg || retire) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + WDT_W'(1);
    end
  end

  // Sticky watchdog flag: a simultaneous halt wins, CLEAR in IDLE wipes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_err_reg <= 1'b0;
    end else if (wdt_fire && !halt) begin
      wdt_err_reg <= 1'b1;
    end else if (state_reg == ST_IDLE && accept && cmd_op == OP_CLEAR) begin
      wdt_err_reg <= 1'b0;
    end
  end

  assign wdt_err = wdt_err_reg;
`else
  // Watchdog compiled out; the limit parameter is kept so both builds share one interface.
  logic unused_wdt_cyc;
  assign unused_wdt_cyc = (WDT_CYC != 0);
  assign wdt_fire = 1'b0;
  assign wdt_err  = 1'b0;
`endif

  // Next-state logic. Priority: halt > watchdog > step completion / stop retire > command.
  // A command accepted in a cycle where a higher-priority exit happens is discarded.
  always_comb begin
    state_next   = state_reg;
    steps_next   = steps_reg;
    cycle_next   = cycle_reg;
    instr_next   = instr_reg;
    cmd_err_next = cmd_err_reg;

    // Counters run in every alive cycle, including the one that causes the exit.
    if (alive_reg && cycle_reg != '1) begin
      cycle_next = cycle_reg + CNT_W'(1);
    end
    if (retire && instr_reg != '1) begin
      instr_next = instr_reg + CNT_W'(1);
    end

    if (alive_reg && halt) begin
      state_next = ST_HALTED;
    end else if (wdt_fire) begin
      state_next = ST_HALTED;
    end else if (state_reg == ST_STEP && retire && steps_reg == STEP_W'(1)) begin
      state_next = ST_IDLE;
      steps_next = '0;
    end else if (state_reg == ST_STOPPING && retire) begin
      state_next = ST_IDLE;
    end else begin
      if (state_reg == ST_STEP && retire) begin
        steps_next = steps_reg - STEP_W'(1);
      end
      if (accept) begin
        case (state_reg)
          ST_IDLE: begin
            case (cmd_op)
              OP_RUN: state_next = ST_RUN;
              OP_STEP: begin
                state_next = ST_STEP;
                steps_next = (step_n == '0) ? STEP_W'(1) : step_n;
              end
              OP_CLEAR: begin
                cycle_next   = '0;
                instr_next   = '0;
                cmd_err_next = 1'b0;
              end
              default: cmd_err_next = 1'b1;
            endcase
          end
          ST_RUN, ST_STEP: begin
            if (cmd_op == OP_STOP) begin
              state_next = ST_STOPPING;
            end else begin
              cmd_err_next = 1'b1;
            end
          end
          ST_HALTED: begin
            // Leaving HALTED keeps the counters so the host can read the run totals.
            if (cmd_op == OP_CLEAR) begin
              state_next = ST_IDLE;
            end else begin
              cmd_err_next = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State, registered decoded outputs, step counter and statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      alive_reg   <= 1'b0;
      done_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;
      steps_reg   <= '0;
      cycle_reg   <= '0;
      instr_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      alive_reg   <= (state_next == ST_RUN) || (state_next == ST_STEP) ||
                     (state_next == ST_STOPPING);
      done_reg    <= (state_next == ST_HALTED);
      cmd_err_reg <= cmd_err_next;
      steps_reg   <= steps_next;
      cycle_reg   <= cycle_next;
      instr_reg   <= instr_next;
    end
  end

  assign state       = state_reg;
  assign alive       = alive_reg;
  assign done        = done_reg;
  assign cmd_err     = cmd_err_reg;
  assign cycle_count = cycle_reg;
  assign instr_count = instr_reg;

endmodule
